// File: rtl/gb_pkg.sv
// Shared memory-map constants and DMA state encoding for the OAM DMA engine and the PPU.
package gb_pkg;

    localparam logic [15:0] OAM_BASE    = 16'hFE00;
    localparam int          OAM_LEN     = 160;
    localparam logic [15:0] DMA_REG     = 16'hFF46;
    localparam logic [15:0] HRAM_START  = 16'hFF80;
    localparam logic [15:0] HRAM_END    = 16'hFFFE;
    localparam logic [15:0] IO_START    = 16'hFF00;
    localparam logic [15:0] IO_END      = 16'hFF7F;
    localparam int          START_DELAY = 1;

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_DELAY,
        DMA_RD,
        DMA_WR
    } dma_state_t;

    // Sources in 0xE0-0xFF alias the work RAM mirror, so fold them down by 0x20.
    function automatic logic [7:0] echo_fold(input logic [7:0] hi);
        return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: owns the DMA register, copies one 160-byte page into OAM and
// arbitrates the shared memory bus between the CPU and the copy engine.
module oam_dma
    import gb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_write,
    input  logic        cpu_do_write,
    output logic [7:0]  cpu_data_read,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_write,
    output logic        bus_do_write,
    input  logic [7:0]  bus_data_read,
    output logic        dma_active
);

    dma_state_t  state_reg, state_next;
    logic [7:0]  dma_val_reg, dma_val_next;
    logic [7:0]  src_hi_reg, src_hi_next;
    logic [7:0]  idx_reg, idx_next;
    logic [7:0]  byte_buf_reg, byte_buf_next;
    logic [3:0]  delay_cnt_reg, delay_cnt_next;
    logic        dma_active_reg, dma_active_next;

    logic cpu_hits_reg;
    logic cpu_in_hram;
    logic reg_write;
    logic stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= DMA_IDLE;
            dma_val_reg    <= 8'h00;
            src_hi_reg     <= 8'h00;
            idx_reg        <= 8'h00;
            byte_buf_reg   <= 8'h00;
            delay_cnt_reg  <= 4'd0;
            dma_active_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            dma_val_reg    <= dma_val_next;
            src_hi_reg     <= src_hi_next;
            idx_reg        <= idx_next;
            byte_buf_reg   <= byte_buf_next;
            delay_cnt_reg  <= delay_cnt_next;
            dma_active_reg <= dma_active_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        dma_val_next    = dma_val_reg;
        src_hi_next     = src_hi_reg;
        idx_next        = idx_reg;
        byte_buf_next   = byte_buf_reg;
        delay_cnt_next  = delay_cnt_reg;
        dma_active_next = dma_active_reg;

        cpu_hits_reg = (cpu_addr == DMA_REG);
        cpu_in_hram  = (cpu_addr >= HRAM_START) && (cpu_addr <= HRAM_END);
        reg_write    = cpu_do_write && cpu_hits_reg;
        // HRAM traffic takes the bus away from the copy engine for one cycle.
        stall        = ((state_reg == DMA_RD) || (state_reg == DMA_WR)) && cpu_in_hram;

        bus_addr       = cpu_addr;
        bus_data_write = cpu_data_write;
        bus_do_write   = cpu_do_write && !cpu_hits_reg;
        cpu_data_read  = cpu_hits_reg ? dma_val_reg : bus_data_read;

        if (dma_active_reg && !cpu_hits_reg && !cpu_in_hram) begin
            cpu_data_read = 8'hFF;
            bus_do_write  = 1'b0;
        end

        case (state_reg)
            DMA_DELAY: begin
                if (delay_cnt_reg <= 4'd1) begin
                    state_next = DMA_RD;
                end
                if (delay_cnt_reg != 4'd0) begin
                    delay_cnt_next = delay_cnt_reg - 4'd1;
                end
            end
            DMA_RD: begin
                if (!stall) begin
                    bus_addr      = {src_hi_reg, idx_reg};
                    bus_do_write  = 1'b0;
                    byte_buf_next = bus_data_read;
                    state_next    = DMA_WR;
                end
            end
            DMA_WR: begin
                if (!stall) begin
                    bus_addr       = OAM_BASE + {8'h00, idx_reg};
                    bus_data_write = byte_buf_reg;
                    bus_do_write   = 1'b1;
                    if (idx_reg == 8'(OAM_LEN - 1)) begin
                        state_next      = DMA_IDLE;
                        dma_active_next = 1'b0;
                    end else begin
                        idx_next   = idx_reg + 8'd1;
                        state_next = DMA_RD;
                    end
                end
            end
            default: ;
        endcase

        // A register write always wins and restarts the copy from byte 0.
        if (reg_write) begin
            dma_val_next    = cpu_data_write;
            src_hi_next     = echo_fold(cpu_data_write);
            idx_next        = 8'h00;
            delay_cnt_next  = 4'(START_DELAY);
            state_next      = (START_DELAY == 0) ? DMA_RD : DMA_DELAY;
            dma_active_next = 1'b1;
        end
    end

    assign dma_active = dma_active_reg;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a flat 64 KiB bus memory plus a page-copy reference model.
module tb_oam_dma;
    import gb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data_write = 8'h00;
    logic        cpu_do_write = 1'b0;
    logic [7:0]  cpu_data_read;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_write;
    logic        bus_do_write;
    logic [7:0]  bus_data_read;
    logic        dma_active;

    logic [7:0] mem [0:65535];
    logic [7:0] page_ref [0:159];
    logic [7:0] hram_ref [0:15];
    int n_cmp = 0;
    int n_fail = 0;

    oam_dma dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_addr       (cpu_addr),
        .cpu_data_write (cpu_data_write),
        .cpu_do_write   (cpu_do_write),
        .cpu_data_read  (cpu_data_read),
        .bus_addr       (bus_addr),
        .bus_data_write (bus_data_write),
        .bus_do_write   (bus_do_write),
        .bus_data_read  (bus_data_read),
        .dma_active     (dma_active)
    );

    always #5 clk = ~clk;

    assign bus_data_read = mem[bus_addr];
    always @(posedge clk) begin
        if (bus_do_write) mem[bus_addr] = bus_data_write;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic we);
        cpu_addr       = a;
        cpu_data_write = d;
        cpu_do_write   = we;
        #1;
    endtask

    // Reference: the source page is the register value with the echo range folded down.
    task automatic fill_page(input logic [7:0] reg_val, input bit use_xor);
        logic [7:0] hi;
        hi = (reg_val >= 8'd224) ? reg_val - 8'd32 : reg_val;
        for (int i = 0; i < 160; i++) begin
            page_ref[i] = use_xor ? (8'(i) ^ 8'h5A) : 8'($urandom);
            mem[{hi, 8'(i)}] = page_ref[i];
        end
    endtask

    task automatic check_oam(input string tag, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) check(tag, mem[16'hFE00 + 16'(i)], page_ref[i]);
    endtask

    initial begin
        int cnt;
        int stalls;
        int j;
        int a;
        logic [7:0] v;
        logic [7:0] pg;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) hram_ref[i] = 8'h00;

        // Reset state
        drive(16'h1234, 8'h00, 1'b0);
        #10;
        check("rst_active", dma_active, 0);
        check("rst_bus_addr", bus_addr, 16'h1234);
        check("rst_bus_we", bus_do_write, 0);
        drive(DMA_REG, 8'h00, 1'b0);
        check("rst_reg_read", cpu_data_read, 8'h00);
        tick();
        reset = 1'b1;
        tick();

        // Idle pass-through
        drive(16'hC000, 8'h12, 1'b1);
        check("idle_addr", bus_addr, 16'hC000);
        check("idle_we", bus_do_write, 1);
        check("idle_wdata", bus_data_write, 8'h12);
        tick();
        drive(16'hC000, 8'h00, 1'b0);
        check("idle_rdata", cpu_data_read, 8'h12);
        check("idle_rd_we", bus_do_write, 0);
        tick();

        // Basic DMA with lockout checks
        fill_page(8'hC0, 1'b1);
        drive(DMA_REG, 8'hC0, 1'b1);
        check("reg_not_fwd", bus_do_write, 0);
        cnt = 0;
        for (int t = 0; t < 2000; t++) begin
            tick();
            if (!dma_active) break;
            cnt++;
            drive(16'h0000, 8'h00, 1'b0);
            if (cnt == 10) begin
                drive(16'hC000, 8'h00, 1'b0);
                check("lock_read", cpu_data_read, 8'hFF);
            end else if (cnt == 11) begin
                drive(16'hD000, 8'h77, 1'b1);
            end else if (cnt == 12) begin
                drive(DMA_REG, 8'h00, 1'b0);
                check("reg_read_dma", cpu_data_read, 8'hC0);
            end
        end
        check("basic_len", cnt, START_DELAY + 2 * OAM_LEN);
        check("lock_write", mem[16'hD000], 8'h00);
        check_oam("basic_oam", 0, 159);
        drive(DMA_REG, 8'h00, 1'b0);
        check("reg_read_idle", cpu_data_read, 8'hC0);
        tick();

        // Stall: HRAM access on every third active cycle
        pg = 8'($urandom_range(32'hDF, 32'hC2));
        fill_page(pg, 1'b0);
        drive(DMA_REG, pg, 1'b1);
        cnt = 0;
        stalls = 0;
        for (int t = 0; t < 2000; t++) begin
            tick();
            if (!dma_active) break;
            cnt++;
            if (cnt % 3 == 0) begin
                j = cnt / 3;
                if (j % 2 == 1) begin
                    a = (j / 2) % 16;
                    v = 8'($urandom);
                    hram_ref[a] = v;
                    drive(HRAM_START + 16'(a), v, 1'b1);
                end else begin
                    a = ((j - 1) / 2) % 16;
                    drive(HRAM_START + 16'(a), 8'h00, 1'b0);
                    check("hram_read", cpu_data_read, hram_ref[a]);
                end
                if (cnt > START_DELAY) stalls++;
            end else begin
                drive(16'h0000, 8'h00, 1'b0);
            end
        end
        check("stall_len", cnt, START_DELAY + 2 * OAM_LEN + stalls);
        check_oam("stall_oam", 0, 159);
        tick();

        // Restart with echo fold
        for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'h00;
        fill_page(8'hE1, 1'b0);
        drive(DMA_REG, 8'hE1, 1'b1);
        cnt = 0;
        for (int t = 0; t < 2000; t++) begin
            tick();
            if (!dma_active) break;
            cnt++;
            if (cnt == 49) begin
                drive(DMA_REG, 8'h00, 1'b0);
                check("echo_reg", cpu_data_read, 8'hE1);
            end else if (cnt == 50) begin
                check_oam("echo_first", 0, 19);
                fill_page(8'hC1, 1'b0);
                drive(DMA_REG, 8'hC1, 1'b1);
            end else begin
                drive(16'h0000, 8'h00, 1'b0);
            end
        end
        check("restart_len", cnt, 50 + START_DELAY + 2 * OAM_LEN);
        check_oam("restart_oam", 0, 159);
        tick();

        // Asynchronous reset while byte 80 is being read
        for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'hEE;
        fill_page(8'hC2, 1'b0);
        drive(DMA_REG, 8'hC2, 1'b1);
        cnt = 0;
        for (int t = 0; t < 2000; t++) begin
            tick();
            if (!dma_active) break;
            cnt++;
            if (cnt == 2 * 80 + 2) begin
                drive(16'h1234, 8'h00, 1'b0);
                reset = 1'b0;
                #1;
                check("arst_active", dma_active, 0);
                check("arst_bus_addr", bus_addr, 16'h1234);
                check("arst_bus_we", bus_do_write, 0);
                drive(DMA_REG, 8'h00, 1'b0);
                check("arst_reg", cpu_data_read, 8'h00);
                break;
            end
            drive(16'h0000, 8'h00, 1'b0);
        end
        check("arst_reached", cnt, 162);
        drive(16'h0000, 8'h00, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("arst_idle", dma_active, 0);
        check_oam("arst_kept", 0, 79);
        for (int i = 80; i < 160; i++) check("arst_untouched", mem[16'hFE00 + 16'(i)], 8'hEE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sits between the CPU bus and the shared memory bus (VRAM/OAM/PPU I/O, WRAM, cartridge).
- Owns register 0xFF46 (DMA) and copies 160 bytes from 0xXX00 to OAM at 0xFE00.
- During a transfer it arbitrates the memory bus: the DMA engine gets the bus, and the CPU is limited to HRAM and the DMA register.
- Exports `dma_active` so the PPU can block CPU OAM access.

Parameters:
- OAM_BASE, 'hFE00, first OAM destination address
- OAM_LEN, 160, bytes per transfer
- DMA_REG, 'hFF46, DMA start/source register address
- HRAM_START, 'hFF80, first CPU-accessible address during DMA
- HRAM_END, 'hFFFE, last CPU-accessible address during DMA
- START_DELAY, 1, idle cycles between register write and first DMA read

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- cpu_addr  in  16  CPU address
- cpu_data_write  in  8  CPU write data
- cpu_do_write  in  1  CPU write strobe
- cpu_data_read  out  8  read data returned to CPU
- bus_addr  out  16  shared memory bus address
- bus_data_write  out  8  shared memory bus write data
- bus_do_write  out  1  shared memory bus write strobe
- bus_data_read  in  8  shared bus read data, combinational, valid in the same cycle as bus_addr
- dma_active  out  1  high while a transfer is pending or running

Behaviour:
- Reset (async, reset==0):
  - state=IDLE, dma_reg=0, src_hi=0, idx=0, byte_buf=0, delay count=0, dma_active=0.
  - Bus outputs are pass-through of the CPU, as in IDLE.
- States: IDLE, DELAY, RD, WR.
- IDLE:
  - bus_addr=cpu_addr, bus_data_write=cpu_data_write, bus_do_write=cpu_do_write, cpu_data_read=bus_data_read.
  - Exception: cpu_addr==DMA_REG is never forwarded. Writes are not driven to the bus (bus_do_write=0); reads return dma_reg.
- Register write (cpu_do_write && cpu_addr==DMA_REG), in any state:
  - dma_reg<=data.
  - src_hi<= (data>='hE0) ? data-'h20 : data (echo-RAM fold).
  - idx<=0, state<=DELAY with count=START_DELAY, dma_active<=1.
  - A write while a transfer is running restarts from byte 0 with the new source.
- DELAY: bus is still CPU pass-through, with DMA restrictions already applied. Count decrements; state moves to RD after START_DELAY cycles (if 0, straight to RD).
- RD:
  - bus_addr={src_hi,idx}, bus_do_write=0.
  - byte_buf<=bus_data_read at the end of the cycle; then WR.
- WR:
  - bus_addr=OAM_BASE+idx, bus_data_write=byte_buf, bus_do_write=1.
  - If idx==OAM_LEN-1, go to IDLE and dma_active<=0; else idx<=idx+1 and go to RD.
- Nominal transfer length: START_DELAY+2*OAM_LEN cycles (321 cycles at defaults).
- CPU restrictions while dma_active:
  - Reads outside [HRAM_START,HRAM_END] and DMA_REG return 'hFF.
  - Writes outside that range and DMA_REG are dropped.
- CPU access to HRAM while in RD or WR:
  - The CPU wins the bus for that cycle (pass-through).
  - The DMA step stalls: state, idx and byte_buf are held, and byte_buf is not captured in a stalled RD.
- CPU access to HRAM in DELAY: passes through; the delay count still advances.
- Width rules:
  - idx is 8 bits.
  - OAM_BASE+idx is computed in 16 bits, so there is no wrap inside 0xFE00–0xFE9F.
  - {src_hi,idx} never crosses a 256-byte page.
- dma_active rises on the cycle after the register write and falls on the cycle after the final WR.

Decomposition:
- Shared package `gb_pkg`: address constants (OAM_BASE, DMA_REG, HRAM range, IO range) and the DMA state encoding. The PPU uses the same address constants.
- No sub-module needed; a single FSM plus combinational bus mux.

Test Plan:
- Idle pass-through: CPU writes 'h12 to 'hC000, then reads it back -> bus shows the same address and strobe; cpu_data_read='h12; 'hFF46 write is not driven onto the bus.
- Basic DMA: preload 'hC000–'hC09F with i^'h5A, write 'hC0 to 'hFF46 -> dma_active high for 321 cycles; 'hFE00–'hFE9F hold i^'h5A; reading 'hFF46 returns 'hC0.
- Lockout: during DMA, CPU reads 'hC000 -> 'hFF; CPU writes 'hD000 -> not written; CPU reads/writes 'hFF80 -> works normally.
- Stall: an HRAM access on every third cycle of the transfer -> transfer length extends by the number of stalled RD/WR cycles; OAM contents still correct.
- Restart/echo: write 'hE1 to 'hFF46, then write 'hC1 after 50 cycles -> the first copy uses source 'hC100 (fold); the restart recopies from 'hC100 byte 0; total active time is 50+321 cycles.
- Async reset mid-transfer: drop reset at byte 80 -> immediately dma_active=0 and bus in pass-through; 'hFF46 reads 0; OAM bytes 80+ are left untouched.
